// File: rtl/mem_ctrl_burst_if.sv
// Requester and byte-bus signals of the burst memory controller.
// slave = controller side, master = requesters plus RAM/IO port.
interface mem_ctrl_burst_if #(
  parameter int LINE_WORDS = 4
);
  logic [7:0]              mem_din;
  logic                    io_buffer_full;
  logic [7:0]              mem_dout;
  logic [31:0]             mem_a;
  logic                    mem_wr;

  logic                    ic_req;
  logic [31:0]             ic_addr;
  logic                    ic_flush;
  logic                    ic_valid;
  logic [32*LINE_WORDS-1:0] ic_line;

  logic                    lsb_req;
  logic                    lsb_we;
  logic [1:0]              lsb_size;
  logic                    lsb_signed;
  logic [31:0]             lsb_addr;
  logic [31:0]             lsb_wdata;
  logic                    lsb_valid;
  logic [31:0]             lsb_rdata;

  modport slave (
    input  mem_din, io_buffer_full,
    input  ic_req, ic_addr, ic_flush,
    input  lsb_req, lsb_we, lsb_size, lsb_signed,
    input  lsb_addr, lsb_wdata,
    output mem_dout, mem_a, mem_wr,
    output ic_valid, ic_line,
    output lsb_valid, lsb_rdata
  );

  modport master (
    output mem_din, io_buffer_full,
    output ic_req, ic_addr, ic_flush,
    output lsb_req, lsb_we, lsb_size, lsb_signed,
    output lsb_addr, lsb_wdata,
    input  mem_dout, mem_a, mem_wr,
    input  ic_valid, ic_line,
    input  lsb_valid, lsb_rdata
  );
endinterface

// File: rtl/mem_ctrl_burst.sv
// Byte-bus memory controller: icache line bursts and sized LSB accesses.
// Arbitrates with an LSB streak limit so a waiting refill cannot starve.
module mem_ctrl_burst #(
  parameter int          LINE_WORDS = 4,
  parameter int          LSB_STREAK = 4,
  parameter logic [31:0] IO_ADDR0   = 32'h30000,
  parameter logic [31:0] IO_ADDR1   = 32'h30004
) (
  input logic             clk,
  input logic             rst,
  input logic             rdy,
  mem_ctrl_burst_if.slave bus
);
  localparam int LB = 4 * LINE_WORDS;
  localparam int LW = 8 * LB;
  localparam int IW = $clog2(LB);
  localparam int SW = $clog2(LSB_STREAK + 1);

  typedef enum logic [2:0] {
    IDLE, IFETCH, LOAD, STORE, DONE
  } state_t;

  state_t        state, state_n;
  logic [31:0]   mem_a, mem_a_n;
  logic          mem_wr, mem_wr_n;
  logic [7:0]    mem_dout, mem_dout_n;
  logic          ic_valid, ic_valid_n;
  logic [LW-1:0] ic_line, ic_line_n;
  logic          lsb_valid, lsb_valid_n;
  logic [31:0]   lsb_rdata, lsb_rdata_n;
  logic [SW-1:0] streak, streak_n;
  logic [6:0]    cnt, cnt_n;
  logic [6:0]    len, len_n;
  logic [31:0]   ld_buf, ld_buf_n;
  logic [31:0]   st_data, st_data_n;
  logic [1:0]    op_size, op_size_n;
  logic          op_signed, op_signed_n;
  logic          op_io, op_io_n;

  logic          lsb_io;
  logic          lsb_ok;
  logic          ic_ok;
  logic          streak_max;
  logic [6:0]    lsb_len;
  logic [IW-1:0] cap_idx;
  logic [1:0]    ld_idx;
  logic [1:0]    st_idx;

  assign lsb_io = (bus.lsb_addr == IO_ADDR0) ||
                  (bus.lsb_addr == IO_ADDR1);
  assign lsb_ok = bus.lsb_req &&
                  !(bus.lsb_we && bus.io_buffer_full && lsb_io);
  assign ic_ok = bus.ic_req && !bus.ic_flush;
  assign streak_max = (streak == SW'(LSB_STREAK));
  assign cap_idx = IW'(cnt - 7'd1);
  assign ld_idx = cnt[1:0] - 2'd1;
  assign st_idx = cnt[1:0] + 2'd1;

  always_comb begin
    unique case (1'b1)
      bus.lsb_size == 2'd0: lsb_len = 7'd1;
      bus.lsb_size == 2'd1: lsb_len = 7'd2;
      default:              lsb_len = 7'd4;
    endcase
  end

  always_comb begin
    state_n     = state;
    mem_a_n     = mem_a;
    mem_wr_n    = mem_wr;
    mem_dout_n  = mem_dout;
    ic_valid_n  = ic_valid;
    ic_line_n   = ic_line;
    lsb_valid_n = lsb_valid;
    lsb_rdata_n = lsb_rdata;
    streak_n    = streak;
    cnt_n       = cnt;
    len_n       = len;
    ld_buf_n    = ld_buf;
    st_data_n   = st_data;
    op_size_n   = op_size;
    op_signed_n = op_signed;
    op_io_n     = op_io;

    unique case (state)
      IDLE: begin
        if (ic_ok && (!lsb_ok || streak_max)) begin
          state_n  = IFETCH;
          mem_a_n  = bus.ic_addr & ~32'(LB - 1);
          mem_wr_n = 1'b0;
          cnt_n    = 7'd0;
          len_n    = 7'(LB);
          streak_n = '0;
        end else if (lsb_ok) begin
          if (bus.ic_req && !streak_max)
            streak_n = streak + SW'(1);
          cnt_n       = 7'd0;
          len_n       = lsb_len;
          op_size_n   = bus.lsb_size;
          op_signed_n = bus.lsb_signed;
          op_io_n     = lsb_io;
          st_data_n   = bus.lsb_wdata;
          mem_a_n     = bus.lsb_addr;
          if (bus.lsb_we) begin
            state_n    = STORE;
            mem_wr_n   = 1'b1;
            mem_dout_n = bus.lsb_wdata[7:0];
          end else begin
            state_n  = LOAD;
            mem_wr_n = 1'b0;
          end
        end
      end

      IFETCH: begin
        if (bus.ic_flush) begin
          mem_a_n = 32'd0;
          state_n = DONE;
        end else begin
          if (cnt != 7'd0)
            ic_line_n[{cap_idx, 3'b000} +: 8] = bus.mem_din;
          if (cnt == len) begin
            ic_valid_n = 1'b1;
            mem_a_n    = 32'd0;
            state_n    = DONE;
          end else begin
            cnt_n = cnt + 7'd1;
            if (cnt < len - 7'd1)
              mem_a_n = mem_a + 32'd1;
          end
        end
      end

      LOAD: begin
        // RAM answers one cycle late, so byte k lands two edges after its address
        if (cnt != 7'd0)
          ld_buf_n[{ld_idx, 3'b000} +: 8] = bus.mem_din;
        if (cnt == len) begin
          lsb_valid_n = 1'b1;
          mem_a_n     = 32'd0;
          state_n     = DONE;
          unique case (1'b1)
            op_size == 2'd0:
              lsb_rdata_n = {{24{op_signed & ld_buf_n[7]}},
                             ld_buf_n[7:0]};
            op_size == 2'd1:
              lsb_rdata_n = {{16{op_signed & ld_buf_n[15]}},
                             ld_buf_n[15:0]};
            default:
              lsb_rdata_n = ld_buf_n;
          endcase
        end else begin
          cnt_n = cnt + 7'd1;
          if (cnt < len - 7'd1)
            mem_a_n = mem_a + 32'd1;
        end
      end

      STORE: begin
        if (!(op_io && bus.io_buffer_full)) begin
          if (cnt == len - 7'd1) begin
            mem_wr_n    = 1'b0;
            mem_a_n     = 32'd0;
            lsb_valid_n = 1'b1;
            state_n     = DONE;
          end else begin
            cnt_n      = cnt + 7'd1;
            mem_a_n    = mem_a + 32'd1;
            mem_dout_n = st_data[{st_idx, 3'b000} +: 8];
          end
        end
      end

      DONE: begin
        ic_valid_n  = 1'b0;
        lsb_valid_n = 1'b0;
        state_n     = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_a     <= 32'd0;
      mem_wr    <= 1'b0;
      mem_dout  <= 8'd0;
      ic_valid  <= 1'b0;
      ic_line   <= '0;
      lsb_valid <= 1'b0;
      lsb_rdata <= 32'd0;
      streak    <= '0;
      cnt       <= 7'd0;
      len       <= 7'd0;
      ld_buf    <= 32'd0;
      st_data   <= 32'd0;
      op_size   <= 2'd0;
      op_signed <= 1'b0;
      op_io     <= 1'b0;
    end else if (rdy) begin
      state     <= state_n;
      mem_a     <= mem_a_n;
      mem_wr    <= mem_wr_n;
      mem_dout  <= mem_dout_n;
      ic_valid  <= ic_valid_n;
      ic_line   <= ic_line_n;
      lsb_valid <= lsb_valid_n;
      lsb_rdata <= lsb_rdata_n;
      streak    <= streak_n;
      cnt       <= cnt_n;
      len       <= len_n;
      ld_buf    <= ld_buf_n;
      st_data   <= st_data_n;
      op_size   <= op_size_n;
      op_signed <= op_signed_n;
      op_io     <= op_io_n;
    end
  end

  assign bus.mem_a     = mem_a;
  assign bus.mem_wr    = mem_wr;
  assign bus.mem_dout  = mem_dout;
  assign bus.ic_valid  = ic_valid;
  assign bus.ic_line   = ic_line;
  assign bus.lsb_valid = lsb_valid;
  assign bus.lsb_rdata = lsb_rdata;
endmodule

// File: tb/tb_mem_ctrl_burst.sv
// Directed bench for mem_ctrl_burst with a registered byte RAM model.
// Latencies count edges after the grant edge.
module tb_mem_ctrl_burst;
  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [7:0]  ram [65536];
  logic [31:0] wr_a [$];
  logic [7:0]  wr_d [$];

  localparam logic [127:0] LINE_1000 =
    128'h1F1E1D1C_1B1A1918_17161514_13121110;

  mem_ctrl_burst_if #(.LINE_WORDS(4)) bus ();

  mem_ctrl_burst #(
    .LINE_WORDS(4),
    .LSB_STREAK(4),
    .IO_ADDR0  (32'h30000),
    .IO_ADDR1  (32'h30004)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.mem_din <= ram[bus.mem_a[15:0]];

  task automatic idle_inputs();
    bus.io_buffer_full = 1'b0;
    bus.ic_req     = 1'b0;
    bus.ic_addr    = 32'd0;
    bus.ic_flush   = 1'b0;
    bus.lsb_req    = 1'b0;
    bus.lsb_we     = 1'b0;
    bus.lsb_size   = 2'd0;
    bus.lsb_signed = 1'b0;
    bus.lsb_addr   = 32'd0;
    bus.lsb_wdata  = 32'd0;
  endtask

  task automatic run_lsb(input logic we, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, output int lat);
    wr_a.delete();
    wr_d.delete();
    bus.lsb_we = we;
    bus.lsb_size = sz;
    bus.lsb_signed = sg;
    bus.lsb_addr = a;
    bus.lsb_wdata = wd;
    bus.lsb_req = 1'b1;
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.mem_wr) begin
        wr_a.push_back(bus.mem_a);
        wr_d.push_back(bus.mem_dout);
      end
      if (bus.lsb_valid) begin
        lat = i;
        break;
      end
    end
    bus.lsb_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_ic(input logic [31:0] a, output int lat,
                        output logic [31:0] amin,
                        output logic [31:0] amax, output int nwr);
    bus.ic_addr = a;
    bus.ic_req = 1'b1;
    lat = -1;
    amin = 32'hFFFF_FFFF;
    amax = 32'd0;
    nwr = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.mem_wr) nwr++;
      if (bus.mem_a != 32'd0) begin
        if (bus.mem_a < amin) amin = bus.mem_a;
        if (bus.mem_a > amax) amax = bus.mem_a;
      end
      if (bus.ic_valid) begin
        lat = i;
        break;
      end
    end
    bus.ic_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rdy = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.mem_wr !== 1'b0 || bus.mem_a !== 32'd0 ||
        bus.mem_dout !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_bus: got wr=%b a=%h d=%h want 0/0/0",
               bus.mem_wr, bus.mem_a, bus.mem_dout);
    end
    n_cmp++;
    if (bus.ic_valid !== 1'b0 || bus.lsb_valid !== 1'b0 ||
        bus.ic_line !== 128'd0 || bus.lsb_rdata !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_out: got icv=%b lv=%b line=%h rd=%h want 0",
               bus.ic_valid, bus.lsb_valid, bus.ic_line, bus.lsb_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rdy_hold();
    logic moved;
    int   lat;
    moved = 1'b0;
    lat = -1;
    rdy = 1'b0;
    bus.lsb_we = 1'b0;
    bus.lsb_size = 2'd2;
    bus.lsb_signed = 1'b0;
    bus.lsb_addr = 32'h100;
    bus.lsb_req = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.mem_a !== 32'd0 || bus.lsb_valid !== 1'b0) moved = 1'b1;
    end
    n_cmp++;
    if (moved !== 1'b0) begin
      n_bad++;
      $display("FAIL rdy_hold: got moved=%b want 0", moved);
    end
    rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.lsb_valid) begin
        lat = i;
        break;
      end
    end
    bus.lsb_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (lat !== 5 || bus.lsb_rdata !== 32'h44332211) begin
      n_bad++;
      $display("FAIL rdy_resume: got lat=%0d rd=%h want 5 44332211",
               lat, bus.lsb_rdata);
    end
  endtask

  task automatic test_load();
    int lat;
    run_lsb(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, lat);
    n_cmp++;
    if (lat !== 5 || bus.lsb_rdata !== 32'h44332211) begin
      n_bad++;
      $display("FAIL lw: got lat=%0d rd=%h want 5 44332211",
               lat, bus.lsb_rdata);
    end
    n_cmp++;
    if (wr_a.size() !== 0) begin
      n_bad++;
      $display("FAIL lw_nowr: got %0d writes want 0", wr_a.size());
    end
    run_lsb(1'b0, 2'd0, 1'b1, 32'h200, 32'd0, lat);
    n_cmp++;
    if (lat !== 2 || bus.lsb_rdata !== 32'hFFFFFF80) begin
      n_bad++;
      $display("FAIL lb: got lat=%0d rd=%h want 2 ffffff80",
               lat, bus.lsb_rdata);
    end
    run_lsb(1'b0, 2'd0, 1'b0, 32'h200, 32'd0, lat);
    n_cmp++;
    if (bus.lsb_rdata !== 32'h00000080) begin
      n_bad++;
      $display("FAIL lbu: got %h want 00000080", bus.lsb_rdata);
    end
    run_lsb(1'b0, 2'd1, 1'b0, 32'h202, 32'd0, lat);
    n_cmp++;
    if (lat !== 3 || bus.lsb_rdata !== 32'h00008001) begin
      n_bad++;
      $display("FAIL lhu: got lat=%0d rd=%h want 3 00008001",
               lat, bus.lsb_rdata);
    end
    run_lsb(1'b0, 2'd1, 1'b1, 32'h202, 32'd0, lat);
    n_cmp++;
    if (bus.lsb_rdata !== 32'hFFFF8001) begin
      n_bad++;
      $display("FAIL lh: got %h want ffff8001", bus.lsb_rdata);
    end
  endtask

  task automatic test_store();
    int lat;
    run_lsb(1'b1, 2'd1, 1'b0, 32'h300, 32'h1234BEEF, lat);
    n_cmp++;
    if (lat !== 2 || wr_a.size() !== 2) begin
      n_bad++;
      $display("FAIL sh_timing: got lat=%0d wr=%0d want 2 2",
               lat, wr_a.size());
    end
    n_cmp++;
    if (wr_a.size() != 2 || wr_a[0] !== 32'h300 || wr_d[0] !== 8'hEF ||
        wr_a[1] !== 32'h301 || wr_d[1] !== 8'hBE) begin
      n_bad++;
      $display("FAIL sh_bytes: got %0d writes want EF@300 BE@301",
               wr_a.size());
    end
    n_cmp++;
    if (bus.lsb_rdata !== 32'hFFFF8001) begin
      n_bad++;
      $display("FAIL rdata_hold: got %h want ffff8001", bus.lsb_rdata);
    end
  endtask

  task automatic test_ifetch();
    int lat;
    int nwr;
    logic [31:0] amin, amax;
    run_ic(32'h1008, lat, amin, amax, nwr);
    n_cmp++;
    if (lat !== 17 || nwr !== 0) begin
      n_bad++;
      $display("FAIL ic_lat: got lat=%0d wr=%0d want 17 0", lat, nwr);
    end
    n_cmp++;
    if (amin !== 32'h1000 || amax !== 32'h100F) begin
      n_bad++;
      $display("FAIL ic_addr: got %h..%h want 1000..100f", amin, amax);
    end
    n_cmp++;
    if (bus.ic_line !== LINE_1000) begin
      n_bad++;
      $display("FAIL ic_line: got %h want %h", bus.ic_line, LINE_1000);
    end
  endtask

  task automatic test_flush();
    logic found;
    logic bad;
    int   lat;
    found = 1'b0;
    bad = 1'b0;
    bus.ic_addr = 32'h1008;
    bus.ic_req = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.mem_a == 32'h1005) begin
        found = 1'b1;
        break;
      end
    end
    bus.ic_flush = 1'b1;
    bus.ic_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (found !== 1'b1 || bus.mem_a !== 32'd0 ||
        bus.ic_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL flush: got found=%b a=%h icv=%b want 1 0 0",
               found, bus.mem_a, bus.ic_valid);
    end
    bus.ic_flush = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.ic_valid !== 1'b0 || bus.mem_a !== 32'd0) bad = 1'b1;
    end
    n_cmp++;
    if (bad !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_quiet: got bad=%b want 0", bad);
    end
    run_lsb(1'b0, 2'd0, 1'b1, 32'h200, 32'd0, lat);
    n_cmp++;
    if (lat !== 2 || bus.lsb_rdata !== 32'hFFFFFF80) begin
      n_bad++;
      $display("FAIL flush_after: got lat=%0d rd=%h want 2 ffffff80",
               lat, bus.lsb_rdata);
    end
  endtask

  task automatic test_io_stall();
    int ic_at, ls_at, nwr;
    logic wr_full;
    logic [31:0] a0;
    logic [7:0] d0;
    ic_at = -1;
    ls_at = -1;
    nwr = 0;
    wr_full = 1'b0;
    a0 = 32'd0;
    d0 = 8'd0;
    bus.io_buffer_full = 1'b1;
    bus.lsb_we = 1'b1;
    bus.lsb_size = 2'd0;
    bus.lsb_addr = 32'h30000;
    bus.lsb_wdata = 32'hDEADBEA5;
    bus.lsb_req = 1'b1;
    bus.ic_addr = 32'h1000;
    bus.ic_req = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.mem_wr) begin
        if (nwr == 0) begin
          a0 = bus.mem_a;
          d0 = bus.mem_dout;
        end
        nwr++;
        if (bus.io_buffer_full) wr_full = 1'b1;
      end
      if (bus.ic_valid) begin
        ic_at = i;
        bus.ic_req = 1'b0;
      end
      if (bus.lsb_valid) begin
        ls_at = i;
        break;
      end
      if (i == 9) bus.io_buffer_full = 1'b0;
    end
    bus.lsb_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ic_at !== 17 || ls_at !== 20) begin
      n_bad++;
      $display("FAIL io_order: got ic=%0d st=%0d want 17 20",
               ic_at, ls_at);
    end
    n_cmp++;
    if (nwr !== 1 || a0 !== 32'h30000 || d0 !== 8'hA5 ||
        wr_full !== 1'b0) begin
      n_bad++;
      $display("FAIL io_store: got n=%0d a=%h d=%h wf=%b want 1 30000 a5 0",
               nwr, a0, d0, wr_full);
    end
    n_cmp++;
    if (bus.ic_line !== LINE_1000) begin
      n_bad++;
      $display("FAIL io_line: got %h want %h", bus.ic_line, LINE_1000);
    end
  endtask

  task automatic test_io_hold();
    int   lat;
    logic bad;
    lat = -1;
    bad = 1'b0;
    bus.lsb_we = 1'b1;
    bus.lsb_size = 2'd0;
    bus.lsb_addr = 32'h30004;
    bus.lsb_wdata = 32'h0000005A;
    bus.lsb_req = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.lsb_valid) begin
        lat = i;
        break;
      end
      if (bus.mem_wr !== 1'b1 || bus.mem_dout !== 8'h5A ||
          bus.mem_a !== 32'h30004) bad = 1'b1;
      if (i == 0) bus.io_buffer_full = 1'b1;
      if (i == 3) bus.io_buffer_full = 1'b0;
    end
    bus.lsb_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (lat !== 4 || bad !== 1'b0) begin
      n_bad++;
      $display("FAIL io_hold: got lat=%0d bad=%b want 4 0", lat, bad);
    end
  endtask

  task automatic test_streak();
    logic [9:0] seq;
    int n;
    seq = 10'd0;
    n = 0;
    bus.lsb_we = 1'b0;
    bus.lsb_size = 2'd2;
    bus.lsb_signed = 1'b0;
    bus.lsb_addr = 32'h100;
    bus.lsb_req = 1'b1;
    bus.ic_addr = 32'h1000;
    bus.ic_req = 1'b1;
    for (int i = 0; i < 400 && n < 10; i++) begin
      @(negedge clk);
      if (bus.ic_valid) begin
        seq[n] = 1'b1;
        n++;
      end
      if (bus.lsb_valid) n++;
    end
    bus.ic_req = 1'b0;
    bus.lsb_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (n !== 10 || seq !== 10'h210) begin
      n_bad++;
      $display("FAIL streak: got n=%0d seq=%b want 10 1000010000",
               n, seq);
    end
    n_cmp++;
    if (bus.lsb_rdata !== 32'h44332211) begin
      n_bad++;
      $display("FAIL streak_data: got %h want 44332211", bus.lsb_rdata);
    end
  endtask

  task automatic test_reset_mid();
    logic found;
    int   lat;
    found = 1'b0;
    bus.lsb_we = 1'b1;
    bus.lsb_size = 2'd2;
    bus.lsb_addr = 32'h400;
    bus.lsb_wdata = 32'hCAFEF00D;
    bus.lsb_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.mem_wr && bus.mem_a == 32'h401) begin
        found = 1'b1;
        break;
      end
    end
    rst = 1'b1;
    bus.lsb_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (found !== 1'b1 || bus.mem_wr !== 1'b0 || bus.mem_a !== 32'd0 ||
        bus.lsb_valid !== 1'b0 || bus.ic_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid: got f=%b wr=%b a=%h lv=%b icv=%b want 1 0 0 0 0",
               found, bus.mem_wr, bus.mem_a, bus.lsb_valid, bus.ic_valid);
    end
    n_cmp++;
    if (bus.lsb_rdata !== 32'd0 || bus.ic_line !== 128'd0) begin
      n_bad++;
      $display("FAIL rst_data: got rd=%h line=%h want 0",
               bus.lsb_rdata, bus.ic_line);
    end
    rst = 1'b0;
    @(negedge clk);
    run_lsb(1'b0, 2'd0, 1'b1, 32'h200, 32'd0, lat);
    n_cmp++;
    if (lat !== 2 || bus.lsb_rdata !== 32'hFFFFFF80) begin
      n_bad++;
      $display("FAIL rst_recover: got lat=%0d rd=%h want 2 ffffff80",
               lat, bus.lsb_rdata);
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) ram[a] = 8'(a * 7);
    ram[16'h0100] = 8'h11;
    ram[16'h0101] = 8'h22;
    ram[16'h0102] = 8'h33;
    ram[16'h0103] = 8'h44;
    ram[16'h0200] = 8'h80;
    ram[16'h0202] = 8'h01;
    ram[16'h0203] = 8'h80;
    for (int i = 0; i < 16; i++) ram[16'h1000 + i] = 8'(8'h10 + i);

    test_reset();
    test_rdy_hold();
    test_load();
    test_store();
    test_ifetch();
    test_flush();
    test_io_stall();
    test_io_hold();
    test_streak();
    test_reset_mid();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
